// File: rtl/ctrl_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_pipe
//   Consumer side of the ID-stage control decoder of the 5-stage MIPS core.
//   Latches the decoded control bundle at the end of ID and carries it
//   through EX, MEM and WB, selects each instruction's destination register,
//   detects load-use hazards and counts retired instructions.
//
// Ports
//   clk_i, rst_i          clock (rising edge) and async active-high reset
//   valid_i               ID holds a real instruction
//   RegDst_i .. Jump_i    decoded control bits from ID
//   rs_i, rt_i, rd_i      ID register fields
//   flush_i               kill the ID instruction (taken branch / jump)
//   hold_i                freeze every stage and the retire counter
//   stall_o               load-use hazard, IF/ID and PC must not advance
//   ex_*  / mem_* / wb_*  per-stage control and destination register
//   retired_o             valid instructions that have left WB (wraps)
// ---------------------------------------------------------------------------
module ctrl_pipe #(
  parameter int CNT_W = 32,
  parameter int REG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             RegDst_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             ALUSrc_i,
  input  logic             RegWrite_i,
  input  logic             MemWrite_i,
  input  logic             MemRead_i,
  input  logic             MemtoReg_i,
  input  logic             Branch_i,
  input  logic             Jump_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic             flush_i,
  input  logic             hold_i,
  output logic             stall_o,
  output logic             ex_valid_o,
  output logic [1:0]       ex_ALUOp_o,
  output logic             ex_ALUSrc_o,
  output logic [REG_W-1:0] ex_wreg_o,
  output logic             mem_valid_o,
  output logic             mem_MemRead_o,
  output logic             mem_MemWrite_o,
  output logic             mem_RegWrite_o,
  output logic [REG_W-1:0] mem_wreg_o,
  output logic             wb_valid_o,
  output logic             wb_RegWrite_o,
  output logic             wb_MemtoReg_o,
  output logic [REG_W-1:0] wb_wreg_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam logic [REG_W-1:0] ZERO_REG = {REG_W{1'b0}};
  localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

  // ID-stage combinational results
  logic [REG_W-1:0] idWreg_s;
  logic             usesRt_s;
  logic             hazard_s;
  logic             idBubble_s;

  // Jump is fully resolved in ID; its effect reaches this block via flush_i
  logic             unusedJump_s;

  // EX stage
  logic             exValid_r;
  logic [1:0]       exALUOp_r;
  logic             exALUSrc_r;
  logic             exRegWrite_r;
  logic             exMemWrite_r;
  logic             exMemRead_r;
  logic             exMemtoReg_r;
  logic [REG_W-1:0] exWreg_r;

  // MEM stage
  logic             memValid_r;
  logic             memMemRead_r;
  logic             memMemWrite_r;
  logic             memRegWrite_r;
  logic             memMemtoReg_r;
  logic [REG_W-1:0] memWreg_r;

  // WB stage
  logic             wbValid_r;
  logic             wbRegWrite_r;
  logic             wbMemtoReg_r;
  logic [REG_W-1:0] wbWreg_r;

  logic [CNT_W-1:0] retired_r;

  assign unusedJump_s = Jump_i;

  // Destination select and load-use hazard detection for the ID instruction
  always_comb begin
    idWreg_s   = rt_i;
    usesRt_s   = 1'b0;
    hazard_s   = 1'b0;
    idBubble_s = 1'b1;
    if (RegDst_i) begin
      idWreg_s = rd_i;
    end else begin
      idWreg_s = rt_i;
    end
    // rt is a source unless it is only the immediate-form destination
    usesRt_s = ~ALUSrc_i | MemWrite_i | Branch_i;
    // A load in EX writing a register the ID instruction reads; $0 never hazards
    hazard_s = valid_i & ~flush_i & exValid_r & exMemRead_r
             & (exWreg_r != ZERO_REG)
             & ((exWreg_r == rs_i) | (usesRt_s & (exWreg_r == rt_i)));
    idBubble_s = hazard_s | flush_i | ~valid_i;
  end

  // EX stage register: take the ID bundle or insert a bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exValid_r    <= 1'b0;
      exALUOp_r    <= 2'b00;
      exALUSrc_r   <= 1'b0;
      exRegWrite_r <= 1'b0;
      exMemWrite_r <= 1'b0;
      exMemRead_r  <= 1'b0;
      exMemtoReg_r <= 1'b0;
      exWreg_r     <= ZERO_REG;
    end else if (!hold_i) begin
      if (idBubble_s) begin
        exValid_r    <= 1'b0;
        exALUOp_r    <= 2'b00;
        exALUSrc_r   <= 1'b0;
        exRegWrite_r <= 1'b0;
        exMemWrite_r <= 1'b0;
        exMemRead_r  <= 1'b0;
        exMemtoReg_r <= 1'b0;
        exWreg_r     <= ZERO_REG;
      end else begin
        exValid_r    <= 1'b1;
        exALUOp_r    <= ALUOp_i;
        exALUSrc_r   <= ALUSrc_i;
        exRegWrite_r <= RegWrite_i;
        exMemWrite_r <= MemWrite_i;
        exMemRead_r  <= MemRead_i;
        exMemtoReg_r <= MemtoReg_i;
        exWreg_r     <= idWreg_s;
      end
    end
  end

  // MEM stage register: follows EX unconditionally unless frozen
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      memValid_r    <= 1'b0;
      memMemRead_r  <= 1'b0;
      memMemWrite_r <= 1'b0;
      memRegWrite_r <= 1'b0;
      memMemtoReg_r <= 1'b0;
      memWreg_r     <= ZERO_REG;
    end else if (!hold_i) begin
      memValid_r    <= exValid_r;
      memMemRead_r  <= exMemRead_r;
      memMemWrite_r <= exMemWrite_r;
      memRegWrite_r <= exRegWrite_r;
      memMemtoReg_r <= exMemtoReg_r;
      memWreg_r     <= exWreg_r;
    end
  end

  // WB stage register; the $0 write suppression is folded in here so the
  // register-file enable stays a flop output
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wbValid_r    <= 1'b0;
      wbRegWrite_r <= 1'b0;
      wbMemtoReg_r <= 1'b0;
      wbWreg_r     <= ZERO_REG;
    end else if (!hold_i) begin
      wbValid_r    <= memValid_r;
      wbRegWrite_r <= memRegWrite_r & (memWreg_r != ZERO_REG);
      wbMemtoReg_r <= memMemtoReg_r;
      wbWreg_r     <= memWreg_r;
    end
  end

  // Retire counter: counts the instruction leaving WB at this edge, wraps
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      retired_r <= ZERO_CNT;
    end else if (!hold_i) begin
      retired_r <= retired_r + {{(CNT_W-1){1'b0}}, wbValid_r};
    end
  end

  assign stall_o        = hazard_s;
  assign ex_valid_o     = exValid_r;
  assign ex_ALUOp_o     = exALUOp_r;
  assign ex_ALUSrc_o    = exALUSrc_r;
  assign ex_wreg_o      = exWreg_r;
  assign mem_valid_o    = memValid_r;
  assign mem_MemRead_o  = memMemRead_r;
  assign mem_MemWrite_o = memMemWrite_r;
  assign mem_RegWrite_o = memRegWrite_r;
  assign mem_wreg_o     = memWreg_r;
  assign wb_valid_o     = wbValid_r;
  assign wb_RegWrite_o  = wbRegWrite_r;
  assign wb_MemtoReg_o  = wbMemtoReg_r;
  assign wb_wreg_o      = wbWreg_r;
  assign retired_o      = retired_r;

endmodule

// File: tb/tb_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe
//   Self-checking bench for ctrl_pipe. Two instances share all inputs: one
//   with the default 32-bit retire counter and one with a 4-bit counter so
//   that wrap-around is reachable. The reference model is a queue of the
//   entries that entered EX (youngest last): EX/MEM/WB are simply the last
//   three entries, and an entry falling off the end has retired.
// ---------------------------------------------------------------------------
module tb_ctrl_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0, RegDst = 1'b0, ALUSrc = 1'b0, RegWrite = 1'b0;
  logic MemWrite = 1'b0, MemRead = 1'b0, MemtoReg = 1'b0, Branch = 1'b0, Jump = 1'b0;
  logic [1:0] ALUOp = 2'b00;
  logic [4:0] rs = 5'd0, rt = 5'd0, rd = 5'd0;
  logic flush = 1'b0, hold = 1'b0;

  logic stall, exValid, exALUSrc, memValid, memMemRead, memMemWrite, memRegWrite;
  logic wbValid, wbRegWrite, wbMemtoReg;
  logic [1:0] exALUOp;
  logic [4:0] exWreg, memWreg, wbWreg;
  logic [31:0] retired;

  logic stall4, exValid4, exALUSrc4, memValid4, memMemRead4, memMemWrite4, memRegWrite4;
  logic wbValid4, wbRegWrite4, wbMemtoReg4;
  logic [1:0] exALUOp4;
  logic [4:0] exWreg4, memWreg4, wbWreg4;
  logic [3:0] retired4;

  int nCmp = 0;
  int nBad = 0;

  always #5 clk = ~clk;

  ctrl_pipe #(.CNT_W(32), .REG_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .RegDst_i(RegDst), .ALUOp_i(ALUOp),
    .ALUSrc_i(ALUSrc), .RegWrite_i(RegWrite), .MemWrite_i(MemWrite), .MemRead_i(MemRead),
    .MemtoReg_i(MemtoReg), .Branch_i(Branch), .Jump_i(Jump), .rs_i(rs), .rt_i(rt), .rd_i(rd),
    .flush_i(flush), .hold_i(hold), .stall_o(stall), .ex_valid_o(exValid),
    .ex_ALUOp_o(exALUOp), .ex_ALUSrc_o(exALUSrc), .ex_wreg_o(exWreg),
    .mem_valid_o(memValid), .mem_MemRead_o(memMemRead), .mem_MemWrite_o(memMemWrite),
    .mem_RegWrite_o(memRegWrite), .mem_wreg_o(memWreg), .wb_valid_o(wbValid),
    .wb_RegWrite_o(wbRegWrite), .wb_MemtoReg_o(wbMemtoReg), .wb_wreg_o(wbWreg),
    .retired_o(retired)
  );

  ctrl_pipe #(.CNT_W(4), .REG_W(5)) dut4 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .RegDst_i(RegDst), .ALUOp_i(ALUOp),
    .ALUSrc_i(ALUSrc), .RegWrite_i(RegWrite), .MemWrite_i(MemWrite), .MemRead_i(MemRead),
    .MemtoReg_i(MemtoReg), .Branch_i(Branch), .Jump_i(Jump), .rs_i(rs), .rt_i(rt), .rd_i(rd),
    .flush_i(flush), .hold_i(hold), .stall_o(stall4), .ex_valid_o(exValid4),
    .ex_ALUOp_o(exALUOp4), .ex_ALUSrc_o(exALUSrc4), .ex_wreg_o(exWreg4),
    .mem_valid_o(memValid4), .mem_MemRead_o(memMemRead4), .mem_MemWrite_o(memMemWrite4),
    .mem_RegWrite_o(memRegWrite4), .mem_wreg_o(memWreg4), .wb_valid_o(wbValid4),
    .wb_RegWrite_o(wbRegWrite4), .wb_MemtoReg_o(wbMemtoReg4), .wb_wreg_o(wbWreg4),
    .retired_o(retired4)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       v;
    logic [1:0] aluOp;
    logic       aluSrc;
    logic       regWrite;
    logic       memWrite;
    logic       memRead;
    logic       memtoReg;
    logic [4:0] wreg;
  } ent_t;

  ent_t pipe[$];
  int unsigned retModel = 0;

  // k = 0 -> EX, 1 -> MEM, 2 -> WB; missing entries are bubbles
  function automatic ent_t stg(int k);
    ent_t e = '0;
    if (pipe.size() > k) e = pipe[pipe.size() - 1 - k];
    return e;
  endfunction

  function automatic logic modelStall();
    ent_t ex = stg(0);
    logic readsRt = !ALUSrc || MemWrite || Branch;
    return valid && !flush && ex.v && ex.memRead && (ex.wreg != 5'd0) &&
           ((ex.wreg == rs) || (readsRt && (ex.wreg == rt)));
  endfunction

  // One clock edge; the model advances with the inputs present at the edge
  task automatic tick();
    ent_t nxt = '0;
    logic adv;
    ent_t old;
    if (valid && !flush && !modelStall()) begin
      nxt.v = 1'b1; nxt.aluOp = ALUOp; nxt.aluSrc = ALUSrc; nxt.regWrite = RegWrite;
      nxt.memWrite = MemWrite; nxt.memRead = MemRead; nxt.memtoReg = MemtoReg;
      nxt.wreg = RegDst ? rd : rt;
    end
    adv = !hold;
    @(posedge clk);
    if (rst) begin
      pipe.delete();
      retModel = 0;
    end else if (adv) begin
      old = stg(2);
      if (old.v) retModel++;
      pipe.push_back(nxt);
      if (pipe.size() > 3) pipe.delete(0);
    end
    #1;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic setIn(logic v, logic dst, logic [1:0] op, logic src, logic rw, logic mw,
                       logic mr, logic m2r, logic br, logic [4:0] s, logic [4:0] t, logic [4:0] d);
    valid = v; RegDst = dst; ALUOp = op; ALUSrc = src; RegWrite = rw; MemWrite = mw;
    MemRead = mr; MemtoReg = m2r; Branch = br; Jump = 1'b0; rs = s; rt = t; rd = d;
  endtask

  task automatic nop();                    setIn(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0); endtask
  task automatic addi(logic [4:0] s, logic [4:0] t); setIn(1, 0, 2'b00, 1, 1, 0, 0, 0, 0, s, t, 5'd0); endtask
  task automatic lw(logic [4:0] s, logic [4:0] t);   setIn(1, 0, 2'b00, 1, 1, 0, 1, 1, 0, s, t, 5'd0); endtask
  task automatic sw(logic [4:0] s, logic [4:0] t);   setIn(1, 0, 2'b00, 1, 0, 1, 0, 0, 0, s, t, 5'd0); endtask
  task automatic addR(logic [4:0] s, logic [4:0] t, logic [4:0] d);
    setIn(1, 1, 2'b10, 0, 1, 0, 0, 0, 0, s, t, d);
  endtask

  task automatic doReset();
    rst = 1'b1; hold = 1'b0; flush = 1'b0;
    nop();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    // valid-looking inputs while in reset must not leak anywhere
    rst = 1'b1;
    addi(5'd1, 5'd5);
    #2;
    nCmp++;
    if ({stall, exValid, exWreg, memValid, memWreg, wbValid, wbRegWrite, wbWreg, retired, retired4} !== '0) begin
      nBad++;
      $display("FAIL reset_state: got ex=%b/%0d mem=%b/%0d wb=%b/%0d ret=%0d ret4=%0d, want all 0",
               exValid, exWreg, memValid, memWreg, wbValid, wbWreg, retired, retired4);
    end
    tick();
    nCmp++;
    if ({exValid, exWreg, retired} !== '0) begin
      nBad++;
      $display("FAIL reset_held_edge: got ex_valid=%b ex_wreg=%0d ret=%0d, want 0", exValid, exWreg, retired);
    end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    doReset();
    addi(5'd1, 5'd5);
    tick();
    nop();
    nCmp++;
    if (exValid !== 1'b1 || exWreg !== 5'd5 || exALUSrc !== 1'b1) begin
      nBad++; $display("FAIL addi_ex: got valid=%b wreg=%0d alusrc=%b, want 1/5/1", exValid, exWreg, exALUSrc);
    end
    tick();
    nCmp++;
    if (memValid !== 1'b1 || memWreg !== 5'd5 || memRegWrite !== 1'b1) begin
      nBad++; $display("FAIL addi_mem: got valid=%b wreg=%0d rw=%b, want 1/5/1", memValid, memWreg, memRegWrite);
    end
    tick();
    nCmp++;
    if (wbValid !== 1'b1 || wbRegWrite !== 1'b1 || wbWreg !== 5'd5 || retired !== 32'd0) begin
      nBad++; $display("FAIL addi_wb: got valid=%b rw=%b wreg=%0d ret=%0d, want 1/1/5/0", wbValid, wbRegWrite, wbWreg, retired);
    end
    tick();
    nCmp++;
    if (retired !== 32'd1 || wbValid !== 1'b0) begin
      nBad++; $display("FAIL addi_retire: got ret=%0d wb_valid=%b, want 1/0", retired, wbValid);
    end
    // addi writing $0 must not enable the register file
    addi(5'd1, 5'd0);
    tick(); nop(); tick(); tick();
    nCmp++;
    if (wbValid !== 1'b1 || wbRegWrite !== 1'b0) begin
      nBad++; $display("FAIL wb_no_r0: got valid=%b rw=%b, want 1/0", wbValid, wbRegWrite);
    end
  endtask

  task automatic test_load_use();
    doReset();
    lw(5'd2, 5'd8);
    tick();
    addR(5'd8, 5'd3, 5'd10);
    #1;
    nCmp++;
    if (stall !== 1'b1) begin nBad++; $display("FAIL lw_add_stall: got %b want 1", stall); end
    tick();
    nCmp++;
    if (exValid !== 1'b0 || stall !== 1'b0 || memMemRead !== 1'b1) begin
      nBad++; $display("FAIL lw_add_bubble: got ex_valid=%b stall=%b mem_rd=%b, want 0/0/1", exValid, stall, memMemRead);
    end
    tick();
    nop();
    nCmp++;
    if (exValid !== 1'b1 || exWreg !== 5'd10 || exALUOp !== 2'b10) begin
      nBad++; $display("FAIL lw_add_late: got ex_valid=%b wreg=%0d op=%b, want 1/10/10", exValid, exWreg, exALUOp);
    end
    // store reading rt of the load also stalls; an addi only writing rt does not
    doReset();
    lw(5'd2, 5'd8);
    tick();
    sw(5'd2, 5'd8);
    #1;
    nCmp++;
    if (stall !== 1'b1) begin nBad++; $display("FAIL lw_sw_stall: got %b want 1", stall); end
    addi(5'd1, 5'd8);
    #1;
    nCmp++;
    if (stall !== 1'b0) begin nBad++; $display("FAIL lw_addi_nostall: got %b want 0", stall); end
  endtask

  task automatic test_zero_reg();
    doReset();
    lw(5'd2, 5'd0);
    tick();
    addR(5'd0, 5'd0, 5'd9);
    #1;
    nCmp++;
    if (stall !== 1'b0 || exValid !== 1'b1 || exWreg !== 5'd0) begin
      nBad++; $display("FAIL r0_nostall: got stall=%b ex_valid=%b ex_wreg=%0d, want 0/1/0", stall, exValid, exWreg);
    end
  endtask

  task automatic test_flush();
    doReset();
    lw(5'd2, 5'd8);
    tick();
    addR(5'd8, 5'd3, 5'd10);
    flush = 1'b1;
    #1;
    nCmp++;
    if (stall !== 1'b0) begin nBad++; $display("FAIL flush_stall: got %b want 0", stall); end
    tick();
    flush = 1'b0;
    nop();
    nCmp++;
    if (exValid !== 1'b0 || exWreg !== 5'd0 || memValid !== 1'b1) begin
      nBad++; $display("FAIL flush_bubble: got ex_valid=%b ex_wreg=%0d mem_valid=%b, want 0/0/1", exValid, exWreg, memValid);
    end
  endtask

  task automatic test_hold();
    doReset();
    addi(5'd1, 5'd5); tick();
    nop();            tick();
    lw(5'd2, 5'd8);   tick();
    // EX = lw, MEM = bubble, WB = addi
    addR(5'd8, 5'd3, 5'd10);
    hold = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nCmp++;
      if (stall !== 1'b1 || exValid !== 1'b1 || exWreg !== 5'd8 || memValid !== 1'b0 ||
          wbValid !== 1'b1 || wbWreg !== 5'd5 || retired !== 32'd0) begin
        nBad++;
        $display("FAIL hold_freeze[%0d]: got stall=%b ex=%b/%0d mem=%b wb=%b/%0d ret=%0d, want 1 1/8 0 1/5 0",
                 i, stall, exValid, exWreg, memValid, wbValid, wbWreg, retired);
      end
    end
    hold = 1'b0;
    tick();
    nCmp++;
    if (exValid !== 1'b0 || memMemRead !== 1'b1 || memWreg !== 5'd8 || wbValid !== 1'b0 || retired !== 32'd1) begin
      nBad++;
      $display("FAIL hold_release: got ex_valid=%b mem_rd=%b mem_wreg=%0d wb_valid=%b ret=%0d, want 0 1 8 0 1",
               exValid, memMemRead, memWreg, wbValid, retired);
    end
    tick();
    nop();
    nCmp++;
    if (exValid !== 1'b1 || exWreg !== 5'd10) begin
      nBad++; $display("FAIL hold_resume: got ex_valid=%b ex_wreg=%0d, want 1/10", exValid, exWreg);
    end
  endtask

  task automatic test_random();
    ent_t ex, mem, wb;
    logic [26:0] expV, actV, actV4;
    doReset();
    for (int c = 0; c < 300; c++) begin
      setIn(($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      Jump  = 1'($urandom);
      flush = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      #1;
      ex = stg(0); mem = stg(1); wb = stg(2);
      expV  = {modelStall(), ex.v, ex.aluOp, ex.aluSrc, ex.wreg,
               mem.v, mem.memRead, mem.memWrite, mem.regWrite, mem.wreg,
               wb.v, (wb.regWrite && wb.wreg != 5'd0), wb.memtoReg, wb.wreg};
      actV  = {stall, exValid, exALUOp, exALUSrc, exWreg, memValid, memMemRead, memMemWrite,
               memRegWrite, memWreg, wbValid, wbRegWrite, wbMemtoReg, wbWreg};
      actV4 = {stall4, exValid4, exALUOp4, exALUSrc4, exWreg4, memValid4, memMemRead4, memMemWrite4,
               memRegWrite4, memWreg4, wbValid4, wbRegWrite4, wbMemtoReg4, wbWreg4};
      nCmp++;
      if (actV !== expV || actV4 !== expV || retired !== retModel || retired4 !== 4'(retModel)) begin
        nBad++;
        $display("FAIL random[%0d]: got %h/%h ret=%0d/%0d, want %h ret=%0d/%0d",
                 c, actV, actV4, retired, retired4, expV, retModel, 4'(retModel));
      end
      tick();
    end
    hold = 1'b0; flush = 1'b0; nop();
  endtask

  task automatic test_mid_reset();
    doReset();
    for (int i = 0; i < 8; i++) begin
      addi(5'd1, 5'(i + 1));
      tick();
    end
    nCmp++;
    if (retired !== 32'd5) begin nBad++; $display("FAIL midrst_pre: got ret=%0d want 5", retired); end
    #3;
    rst = 1'b1;
    #1;
    nCmp++;
    if ({stall, exValid, exWreg, memValid, memWreg, wbValid, wbRegWrite, wbWreg, retired, retired4} !== '0) begin
      nBad++;
      $display("FAIL midrst_async: got ex=%b/%0d mem=%b/%0d wb=%b/%0d ret=%0d, want all 0",
               exValid, exWreg, memValid, memWreg, wbValid, wbWreg, retired);
    end
    nop();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_wrap();
    int edges = 0;
    doReset();
    for (int i = 0; i < 21; i++) begin
      if (i < 17) addi(5'd1, 5'(i % 7 + 1));
      else nop();
      tick();
      edges++;
      if (edges == 18) begin
        nCmp++;
        if (retired4 !== 4'd15) begin nBad++; $display("FAIL wrap_15: got %0d want 15", retired4); end
      end
      if (edges == 19) begin
        nCmp++;
        if (retired4 !== 4'd0) begin nBad++; $display("FAIL wrap_0: got %0d want 0", retired4); end
      end
    end
    nCmp++;
    if (retired4 !== 4'd1 || retired !== 32'd17) begin
      nBad++; $display("FAIL wrap_end: got ret4=%0d ret=%0d, want 1/17", retired4, retired);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_hold();
    test_random();
    test_mid_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
